// File: rtl/mod_acc_pkg.sv
// Shared definitions for the streaming ones'-complement accumulator and related modular blocks.
// State encoding and small helpers are kept here so other modular datapaths can reuse them.
package mod_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest end-around-carry adder other modular blocks are expected to instantiate.
    localparam int EAC_MAX_W = 64;

    function automatic state_t state_after_word(input logic last);
        return last ? ST_DONE : ST_ACC;
    endfunction

endpackage

// File: rtl/mod_accumulator_eac_adder.sv
// Combinational end-around-carry adder: sum = (a + b) mod (2^WIDTH - 1), ones'-complement form.
// A single carry fold is enough because a folded carry can never overflow again.
module eac_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw[WIDTH]};

endmodule

// File: rtl/mod_accumulator.sv
// Framed streaming accumulator producing a ones'-complement residue, word count and saturation flag.
// Results are held in DONE until the downstream accepts them; clr never drops a finished result.
//
//   state   | meaning
//   IDLE    | no frame in progress, acc/cnt cleared, accepting first word
//   ACC     | frame in progress, folding each accepted word into acc
//   DONE    | result registered on the outputs, input stalled until taken
module mod_accumulator
    import mod_acc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 16,
    parameter bit INVERT    = 1'b0,
    parameter bit NORM_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, eac_sum;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;
    logic             rdy_en;
    logic             xfer;

    function automatic logic [WIDTH-1:0] fmt_sum(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] v;
        v = r;
        if (NORM_ZERO && (&v)) v = '0;
        if (INVERT) v = ~v;
        return v;
    endfunction

    eac_adder #(.WIDTH(WIDTH)) u_eac (
        .a   (acc),
        .b   (in_data),
        .sum (eac_sum)
    );

    // rdy_en holds in_ready low through reset and releases it on the first edge after.
    assign in_ready  = rdy_en && (state != ST_DONE);
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        case (state)
            ST_IDLE, ST_ACC: begin
                if (clr) begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                end else if (xfer) begin
                    state_nxt = state_after_word(in_last);
                    if (state == ST_IDLE) begin
                        acc_nxt = in_data;
                        cnt_nxt = CNT_ONE;
                        sat_nxt = 1'b0;
                    end else begin
                        acc_nxt = eac_sum;
                        if (cnt == CNT_MAX) sat_nxt = 1'b1;
                        else                cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            rdy_en      <= 1'b0;
            out_sum     <= '0;
            out_count   <= '0;
            out_cnt_sat <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            sat    <= sat_nxt;
            rdy_en <= 1'b1;
            if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
                out_sum     <= fmt_sum(acc_nxt);
                out_count   <= cnt_nxt;
                out_cnt_sat <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mod_accumulator.sv
// Bench for mod_accumulator: four parameterisations share one stream and are checked each cycle
// against a frame-level arithmetic model, plus literal expectations from hand-computed frames.
module tb_mod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic       a_rdy, a_val, a_sat;
    logic [7:0] a_sum;
    logic [15:0] a_cnt;
    logic       n_rdy, n_val, n_sat;
    logic [7:0] n_sum;
    logic [15:0] n_cnt;
    logic       s_rdy, s_val, s_sat;
    logic [7:0] s_sum;
    logic [1:0] s_cnt;
    logic       w_rdy, w_val, w_sat;
    logic [15:0] w_sum;
    logic [15:0] w_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mod_accumulator #(.WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_rdy),
        .in_data(in_data[7:0]), .in_last(in_last), .out_valid(a_val), .out_ready(out_ready),
        .out_sum(a_sum), .out_count(a_cnt), .out_cnt_sat(a_sat));

    mod_accumulator #(.WIDTH(8), .NORM_ZERO(1'b1)) u_n (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(n_rdy),
        .in_data(in_data[7:0]), .in_last(in_last), .out_valid(n_val), .out_ready(out_ready),
        .out_sum(n_sum), .out_count(n_cnt), .out_cnt_sat(n_sat));

    mod_accumulator #(.WIDTH(8), .CNT_W(2)) u_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_rdy),
        .in_data(in_data[7:0]), .in_last(in_last), .out_valid(s_val), .out_ready(out_ready),
        .out_sum(s_sum), .out_count(s_cnt), .out_cnt_sat(s_sat));

    mod_accumulator #(.WIDTH(16), .INVERT(1'b1)) u_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(w_val), .out_ready(out_ready),
        .out_sum(w_sum), .out_count(w_cnt), .out_cnt_sat(w_sat));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Residue of a plain integer total under ones'-complement rules: zero only if every word was zero.
    function automatic longint exp_sum(input longint tot, input int w, input bit nz, input bit inv);
        longint m, r;
        m = (longint'(1) << w) - 1;
        r = (tot == 0) ? 0 : ((tot - 1) % m) + 1;
        if (nz && r == m) r = 0;
        if (inv) r = r ^ m;
        return r;
    endfunction

    function automatic longint exp_cnt(input longint n, input int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Frame-level model: tracks whether a result is pending and the arithmetic totals of words taken.
    bit     alive, done;
    longint tot8, tot16, nw;
    longint f_tot8, f_tot16, f_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive = 0; done = 0;
            tot8 = 0; tot16 = 0; nw = 0;
        end else begin
            if (alive && !done) begin
                if (clr) begin
                    tot8 = 0; tot16 = 0; nw = 0;
                end else if (in_valid) begin
                    tot8  += in_data[7:0];
                    tot16 += in_data;
                    nw    += 1;
                    if (in_last) begin
                        done = 1;
                        f_tot8 = tot8; f_tot16 = tot16; f_n = nw;
                        tot8 = 0; tot16 = 0; nw = 0;
                    end
                end
            end else if (done && out_ready) begin
                done = 0;
            end
            alive = 1;
        end
    end

    always @(negedge clk) begin
        chk("a_in_ready", a_rdy, alive && !done);
        chk("n_in_ready", n_rdy, alive && !done);
        chk("s_in_ready", s_rdy, alive && !done);
        chk("w_in_ready", w_rdy, alive && !done);
        chk("a_out_valid", a_val, done);
        chk("n_out_valid", n_val, done);
        chk("s_out_valid", s_val, done);
        chk("w_out_valid", w_val, done);
        if (done) begin
            chk("a_out_sum", a_sum, exp_sum(f_tot8, 8, 0, 0));
            chk("n_out_sum", n_sum, exp_sum(f_tot8, 8, 1, 0));
            chk("s_out_sum", s_sum, exp_sum(f_tot8, 8, 0, 0));
            chk("w_out_sum", w_sum, exp_sum(f_tot16, 16, 0, 1));
            chk("a_out_count", a_cnt, exp_cnt(f_n, 16));
            chk("s_out_count", s_cnt, exp_cnt(f_n, 2));
            chk("w_out_count", w_cnt, exp_cnt(f_n, 16));
            chk("a_out_cnt_sat", a_sat, f_n > 65535);
            chk("s_out_cnt_sat", s_sat, f_n > 3);
        end
    end

    task automatic send(input logic [15:0] d, input logic last, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        while (!a_rdy && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) chk("send_timeout", waits, 0);
        @(negedge clk);
    endtask

    task automatic send_nw(input logic [15:0] d, input logic last);
        int w;
        send(d, last, w);
    endtask

    logic [15:0] ip_hdr [10] = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                                 16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};

    initial begin
        int w;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", a_rdy, 0);
        chk("reset_out_valid", a_val, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_sum", w_sum, 0);
        chk("reset_out_count", a_cnt, 0);
        chk("ready_after_release", a_rdy, 1);

        send_nw(16'h00FF, 1'b0);
        send_nw(16'h0001, 1'b1);
        in_valid = 1'b0;
        chk("eac_ff_01_valid", a_val, 1);
        chk("eac_ff_01_sum", a_sum, 8'h01);
        chk("eac_ff_01_count", a_cnt, 2);
        @(negedge clk);

        send_nw(16'h00FF, 1'b0);
        send_nw(16'h00FF, 1'b1);
        in_valid = 1'b0;
        chk("negzero_raw_sum", a_sum, 8'hFF);
        chk("negzero_fold_sum", n_sum, 8'h00);
        @(negedge clk);

        for (int rep = 0; rep < 2; rep++) begin
            out_ready = (rep == 0);
            for (int i = 0; i < 10; i++) send_nw(ip_hdr[i], i == 9);
            in_valid = 1'b0;
            chk("ip_sum", w_sum, 16'hB861);
            chk("ip_count", w_cnt, 10);
            if (rep == 1) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_sum", w_sum, 16'hB861);
                    chk("stall_in_ready", w_rdy, 0);
                end
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                chk("clr_in_done_kept", w_val, 1);
                out_ready = 1'b1;
            end
            @(negedge clk);
        end

        send_nw(16'h0010, 1'b1);
        chk("b2b_first_sum", a_sum, 8'h10);
        chk("b2b_first_count", a_cnt, 1);
        send(16'h0020, 1'b0, w);
        chk("b2b_bubble", w, 1);
        send_nw(16'h0030, 1'b1);
        in_valid = 1'b0;
        chk("b2b_second_sum", a_sum, 8'h50);
        chk("b2b_second_count", a_cnt, 2);
        @(negedge clk);

        send_nw(16'h0001, 1'b0);
        send_nw(16'h0002, 1'b0);
        send_nw(16'h0003, 1'b0);
        clr = 1'b1; in_data = 16'h0077; in_last = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_drop_valid", a_val, 0);
        send_nw(16'h0005, 1'b1);
        in_valid = 1'b0;
        chk("after_clr_sum", a_sum, 8'h05);
        chk("after_clr_count", a_cnt, 1);
        @(negedge clk);

        for (int i = 0; i < 5; i++) send_nw(16'h0001, i == 4);
        in_valid = 1'b0;
        chk("sat_sum", s_sum, 8'h05);
        chk("sat_count", s_cnt, 3);
        chk("sat_flag", s_sat, 1);
        chk("nosat_count", a_cnt, 5);
        chk("nosat_flag", a_sat, 0);
        @(negedge clk);

        send_nw(16'h0011, 1'b0);
        send_nw(16'h0022, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_frame_ready", a_rdy, 0);
        chk("rst_mid_frame_valid", a_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        send_nw(16'h0033, 1'b1);
        in_valid = 1'b0;
        chk("pre_rst_done_valid", a_val, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_done_valid", a_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_nw(16'h0007, 1'b0);
        send_nw(16'h0008, 1'b1);
        in_valid = 1'b0;
        chk("post_rst_sum", a_sum, 8'h0F);
        chk("post_rst_count", a_cnt, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mod_accumulator.md
Name: mod_accumulator

Overview:
- Streaming accumulator that sums a framed sequence of WIDTH-bit words modulo 2^WIDTH-1 using end-around carry (ones'-complement sum).
- Parametrised, sequential successor to the fixed-width combinational modulo adders.
- Intended for checksum generation and checksum checking on data paths, and for residue accumulation in the modular-arithmetic datapath.
- Valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 16, data and sum width in bits (≥2).
- CNT_W, 16, width of the per-frame word counter.
- INVERT, 0, when 1 out_sum is the bitwise complement of the residue (checksum form).
- NORM_ZERO, 0, when 1 an all-ones residue is reported as zero (negative-zero fold; applied before INVERT).

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous abort; discards the frame in progress.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, block accepts a word.
- in_data, input, WIDTH, input word.
- in_last, input, 1, final word of the frame.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, WIDTH, frame residue (post NORM_ZERO/INVERT).
- out_count, output, CNT_W, number of words in the frame (saturating).
- out_cnt_sat, output, 1, word counter saturated during this frame.

Behaviour:
- Clock and reset: one clock clk. rst_n is asynchronous and active-low. The block clears on assertion and releases synchronously to clk.
- Reset values:
  - state=IDLE, acc=0, cnt=0.
  - in_ready=0 while rst_n=0, then 1 from the first clk edge after release.
  - out_valid=0, out_sum=0, out_count=0, out_cnt_sat=0.
- Transfer rules: an input transfer occurs when in_valid&&in_ready at a rising edge; an output transfer when out_valid&&out_ready.
- eac(x,y):
  - s = x+y computed WIDTH+1 wide; result = s[WIDTH-1:0] + s[WIDTH].
  - Single pass is sufficient; the result never carries again.
  - Examples: all-ones+x returns x; all-ones+all-ones returns all-ones.
- States:
  - IDLE: acc=0, cnt=0, in_ready=1.
    - Transfer with in_last=0: acc<=in_data, cnt<=1, go to ACC.
    - Transfer with in_last=1: go to DONE with acc<=in_data, cnt<=1.
  - ACC: in_ready=1.
    - Each transfer: acc<=eac(acc,in_data), cnt<=cnt+1, saturating at 2^CNT_W-1 and setting the sticky sat flag.
    - Transfer with in_last=1: also go to DONE.
  - DONE: in_ready=0, out_valid=1.
    - out_sum, out_count and out_cnt_sat are registered and stable until the output transfer.
    - Output transfer: go to IDLE and clear acc, cnt and sat.
- Latency: the last word accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1). Minimum one bubble cycle between frames (DONE→IDLE).
- Throughput: one word per clock within a frame.
- Output formatting: r = acc; if NORM_ZERO and r==all-ones then r=0; if INVERT then r=~r.
- out_sum is registered from the DONE entry value; it does not change while out_valid=1 and out_ready=0.
- clr:
  - In IDLE/ACC: go to IDLE, acc=0, cnt=0. Any input transfer in the same cycle is dropped, and in_ready is still 1 that cycle (the word is consumed and discarded).
  - In DONE: clr has no effect; the result is never dropped.
- Reset mid-frame or mid-DONE: all state is lost immediately and out_valid falls asynchronously.
- in_data and in_last are ignored when no transfer occurs. in_valid may be held high across the DONE bubble without loss.

Decomposition:
- Shared package/header mod_acc_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2.
  - eac function prototype/width macros reused by other modular blocks.
- Sub-module eac_adder #(WIDTH):
  - Combinational, parametrised end-around-carry adder: a, b → sum.
  - Supersedes the per-width fixed adders.
  - One instance, in the accumulator feedback path.

Test Plan:
- WIDTH=8, frame {0xFF(last=0), 0x01(last=1)} → out_sum=0x01, out_count=2, out_valid one cycle after the last word.
- WIDTH=16, INVERT=1, frame {4500,0073,0000,4000,4011,0000,C0A8,0001,C0A8,00C7} hex → internal residue 0x479E, out_sum=0xB861, out_count=10. Repeat with out_ready held low for 5 cycles → out_sum stable, in_ready=0 throughout.
- WIDTH=8, NORM_ZERO=1, frame {0xFF,0xFF} → residue 0xFF folded, out_sum=0x00. Same frame with NORM_ZERO=0 → 0xFF.
- Back-to-back frames with in_valid held high: {0x10(last)}, {0x20,0x30(last)} → results 0x10/1 then 0x50/2, exactly one bubble cycle between frames, no words lost.
- clr asserted after 3 words of a frame, then frame {0x05(last)} → single result 0x05, count 1. Separately, rst_n pulsed low mid-frame → out_valid=0 and in_ready=0 immediately, and the next frame is correct.
- CNT_W=2, 5-word frame of 0x01 (WIDTH=8) → out_sum=0x05, out_count=3, out_cnt_sat=1.
